ssd_msg_arbiter: RTL and testbench

Shares the 8-digit seven-segment display between two requesters, for example an encryptor result and a decryptor result. Each requester presents a 32-bit word with a request line. The block grants the display round-robin, latches the granted word, and drives multiplexed digit scanning (an, a_to_g, dp) for a fixed dwell time. It then acknowledges the requester and returns to arbitration. It sits between the cipher datapath and the board display pins and replaces direct switch-driven display.

---
 rtl/ssd_pkg.sv | 28 ++
 rtl/ssd_msg_arbiter_if.sv | 18 +
 rtl/ssd_hex_decode.sv | 9 +
 rtl/ssd_msg_arbiter.sv | 143 ++++++++++++++
 tb/tb_ssd_msg_arbiter.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/ssd_pkg.sv
// Shared types and constants for the seven-segment message arbiter:
// FSM states, blanking constants and the active-low hex glyph table.
package ssd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [7:0] AN_OFF    = 8'hFF;

    // Index 15 first; segments active-low with a in bit 6.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h38, 7'h30, 7'h42, 7'h31, 7'h60, 7'h08, 7'h04, 7'h00,
        7'h0F, 7'h20, 7'h24, 7'h4C, 7'h06, 7'h12, 7'h4F, 7'h01
    };

    // Digit-enable mask: a digit is shown if it or any higher nibble is non-zero.
    function automatic logic [7:0] lz_mask(input logic [31:0] w);
        logic [7:0] m;
        m[0] = 1'b1;
        for (int i = 1; i < 8; i++) m[i] = |(w >> (4 * i));
        return m;
    endfunction

endpackage

// File: rtl/ssd_msg_arbiter_if.sv
// Requester/display bundle for ssd_msg_arbiter. master = requester/board side,
// slave = the arbiter itself.
interface ssd_msg_arbiter_if;
    logic [1:0]  req;
    logic [31:0] data0;
    logic [31:0] data1;
    logic [1:0]  gnt;
    logic [1:0]  ack;
    logic        busy;
    logic [6:0]  a_to_g;
    logic [7:0]  an;
    logic        dp;

    modport master (output req, data0, data1,
                    input  gnt, ack, busy, a_to_g, an, dp);
    modport slave  (input  req, data0, data1,
                    output gnt, ack, busy, a_to_g, an, dp);
endinterface

// File: rtl/ssd_hex_decode.sv
// Combinational nibble to active-low seven-segment glyph (0-F).
module ssd_hex_decode
    import ssd_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [6:0] o_seg
);
    assign o_seg = HEX_SEG[i_nib];
endmodule

// File: rtl/ssd_msg_arbiter.sv
// Round-robin arbiter sharing an 8-digit seven-segment display between two
// requesters. Optional macro SSD_LEADING_ZERO_BLANK_EN blanks leading-zero digits.
module ssd_msg_arbiter
    import ssd_pkg::*;
#(
    parameter int SCAN_DIV = 4,
    parameter int DWELL    = 1024
) (
    input  logic              clk,
    input  logic              rst,
    ssd_msg_arbiter_if.slave  bus
);

    localparam int             DW       = (DWELL < 2) ? 1 : $clog2(DWELL);
    localparam logic [DW-1:0]  DWELL_LD = (DWELL < 2) ? '0 : DW'(DWELL - 1);
    localparam int             PW       = (SCAN_DIV < 2) ? 1 : $clog2(SCAN_DIV);
    localparam logic [PW-1:0]  PRE_LD   = (SCAN_DIV < 2) ? '0 : PW'(SCAN_DIV - 1);

    state_e         r_state;
    logic [1:0]     r_gnt;
    logic [1:0]     r_ack;
    logic           r_busy;
    logic           r_win;
    logic           r_rr;
    logic [31:0]    r_shadow;
    logic           r_blank;
    logic [DW-1:0]  r_dwell;

    logic [PW-1:0]  r_pre;
    logic [2:0]     r_idx;
    logic [7:0]     r_an;
    logic [6:0]     r_seg;
    logic           r_dp;

    logic           w_win;
    logic [31:0]    w_data;
    logic [3:0]     w_nib;
    logic [6:0]     w_seg;
    logic [7:0]     w_en;

    // r_rr names the requester favoured on a tie; it flips away from each winner.
    assign w_win  = bus.req[1] & (~bus.req[0] | r_rr);
    assign w_data = w_win ? bus.data1 : bus.data0;

`ifdef SSD_LEADING_ZERO_BLANK_EN
    logic [7:0] r_lz;
    assign w_en = r_lz;
`else
    assign w_en = 8'hFF;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_gnt    <= '0;
            r_ack    <= '0;
            r_busy   <= 1'b0;
            r_win    <= 1'b0;
            r_rr     <= 1'b0;
            r_shadow <= '0;
            r_blank  <= 1'b1;
            r_dwell  <= '0;
`ifdef SSD_LEADING_ZERO_BLANK_EN
            r_lz     <= 8'h01;
`endif
        end else begin
            r_ack <= '0;
            case (r_state)
                IDLE: begin
                    if (|bus.req) begin
                        r_state  <= SHOW;
                        r_gnt    <= w_win ? 2'b10 : 2'b01;
                        r_busy   <= 1'b1;
                        r_win    <= w_win;
                        r_shadow <= w_data;
                        r_blank  <= 1'b0;
                        r_dwell  <= DWELL_LD;
`ifdef SSD_LEADING_ZERO_BLANK_EN
                        r_lz     <= lz_mask(w_data);
`endif
                    end
                end
                SHOW: begin
                    if (r_dwell == '0) begin
                        r_state <= DONE;
                        r_gnt   <= '0;
                        r_ack   <= r_win ? 2'b10 : 2'b01;
                    end else begin
                        r_dwell <= r_dwell - 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_rr    <= ~r_win;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_nib = r_shadow[{r_idx, 2'b00} +: 4];

    ssd_hex_decode u_dec (
        .i_nib (w_nib),
        .o_seg (w_seg)
    );

    // Scan runs regardless of FSM state so the last word stays lit in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pre <= PRE_LD;
            r_idx <= '0;
            r_an  <= AN_OFF;
            r_seg <= SEG_BLANK;
            r_dp  <= 1'b1;
        end else begin
            if (r_pre == '0) begin
                r_pre <= PRE_LD;
                r_idx <= r_idx + 1'b1;
            end else begin
                r_pre <= r_pre - 1'b1;
            end
            if (r_blank) begin
                r_an  <= AN_OFF;
                r_seg <= SEG_BLANK;
                r_dp  <= 1'b1;
            end else begin
                r_an  <= ~(8'd1 << r_idx) | ~w_en;
                r_seg <= w_seg;
                r_dp  <= ~((r_idx == 3'd7) & r_win & w_en[7]);
            end
        end
    end

    assign bus.gnt    = r_gnt;
    assign bus.ack    = r_ack;
    assign bus.busy   = r_busy;
    assign bus.an     = r_an;
    assign bus.a_to_g = r_seg;
    assign bus.dp     = r_dp;

endmodule

// File: tb/tb_ssd_msg_arbiter.sv
// Directed bench for ssd_msg_arbiter with SCAN_DIV=2, DWELL=32.
module tb_ssd_msg_arbiter;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;

    ssd_msg_arbiter_if bus ();

    ssd_msg_arbiter #(.SCAN_DIV(2), .DWELL(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic       bad, sbad, seen0, seen7, saw_dp;
    logic [6:0] seg0, seg7;
    logic [7:0] prev_an, act;
    int         n, k, run, changes, acks;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        n = 0;
        while (bus.busy !== 1'b0 && n < 200) begin tick(); n++; end
        chk(tag, bus.busy, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req = 2'b00; bus.data0 = '0; bus.data1 = '0;
        rst = 1'b1;
        repeat (2) tick();

        // reset values
        chk("rst_an",   bus.an, 8'hFF);
        chk("rst_seg",  bus.a_to_g, 7'h7F);
        chk("rst_dp",   bus.dp, 1'b1);
        chk("rst_gnt",  bus.gnt, 2'b00);
        chk("rst_ack",  bus.ack, 2'b00);
        chk("rst_busy", bus.busy, 1'b0);
        rst = 1'b0;

        // 1: dark while idle
        bad = 1'b0;
        repeat (100) begin
            tick();
            if (bus.an !== 8'hFF || bus.a_to_g !== 7'h7F || bus.dp !== 1'b1 || bus.gnt !== 2'b00)
                bad = 1'b1;
        end
        chk("t1_dark", bad, 1'b0);

        // 2: single request from requester 0
        bus.data0 = 32'h1234_ABCD; bus.req = 2'b01;
        tick();
        chk("t2_gnt", bus.gnt, 2'b01);
        bus.req = 2'b00;
        n = 0; bad = 0; sbad = 0; seen0 = 0; seen7 = 0; seg0 = '0; seg7 = '0;
        prev_an = bus.an; run = 1; changes = 0;
        while (bus.gnt === 2'b01 && n < 100) begin
            if (bus.an === 8'hFE) begin seen0 = 1; seg0 = bus.a_to_g; end
            if (bus.an === 8'h7F) begin seen7 = 1; seg7 = bus.a_to_g; end
            if (bus.dp !== 1'b1) bad = 1'b1;
            n++;
            tick();
            if (bus.an !== prev_an) begin
                if (prev_an !== 8'hFF) begin
                    if (bus.an !== {prev_an[6:0], prev_an[7]}) sbad = 1'b1;
                    if (changes > 0 && run != 2) sbad = 1'b1;
                    changes++;
                end
                run = 1; prev_an = bus.an;
            end else begin
                run++;
            end
        end
        chk("t2_len",     n, 32);
        chk("t2_ack",     bus.ack, 2'b01);
        chk("t2_scan",    {sbad, (changes > 10)}, 2'b01);
        chk("t2_seg0",    {seen0, seg0}, {1'b1, 7'h42});
        chk("t2_seg7",    {seen7, seg7}, {1'b1, 7'h4F});
        chk("t2_dp",      bad, 1'b0);
        tick();
        chk("t2_ack_clr", bus.ack, 2'b00);
        bad = 0; seen0 = 0;
        repeat (20) begin
            tick();
            if (bus.an === 8'hFE) begin seen0 = 1; if (bus.a_to_g !== 7'h42) bad = 1; end
        end
        chk("t2_hold", {bad, seen0}, 2'b01);
        chk("t2_idle_busy", bus.busy, 1'b0);

        // 3: both requesting, alternation from a fresh reset
        rst = 1'b1; tick(); rst = 1'b0;
        bus.data0 = 32'h1357_9BDF; bus.data1 = 32'hFEDC_BA98; bus.req = 2'b11;
        for (int g = 0; g < 4; g++) begin
            n = 0;
            while (bus.gnt === 2'b00 && n < 10) begin tick(); n++; end
            if (g > 0) chk("t3_gap", n, 2);
            chk("t3_gnt", bus.gnt, (g % 2) ? 2'b10 : 2'b01);
            k = 0; bad = 0; saw_dp = 0;
            while (bus.gnt !== 2'b00 && k < 100) begin
                if (k > 0) begin
                    if (bus.an === 8'h7F && bus.dp !== ((g % 2) ? 1'b0 : 1'b1)) bad = 1;
                    if (bus.an !== 8'h7F && bus.dp !== 1'b1) bad = 1;
                    if (bus.dp === 1'b0) saw_dp = 1;
                end
                k++;
                tick();
            end
            chk("t3_dp", bad, 1'b0);
            chk("t3_dp_seen", saw_dp, g % 2);
        end
        bus.req = 2'b00;
        drain("t3_drain");

        // 4: one-cycle request, data changes during SHOW
        bus.data0 = 32'h8765_4321; bus.req = 2'b01;
        tick();
        chk("t4_gnt", bus.gnt, 2'b01);
        bus.req = 2'b00; bus.data0 = 32'hFFFF_FFFF;
        tick();
        bad = 0; acks = 0; seen0 = 0; seen7 = 0;
        repeat (80) begin
            if (bus.gnt === 2'b01) begin
                if (bus.an === 8'hFE) begin seen0 = 1; if (bus.a_to_g !== 7'h4F) bad = 1; end
                if (bus.an === 8'h7F) begin seen7 = 1; if (bus.a_to_g !== 7'h00) bad = 1; end
            end
            if (bus.ack !== 2'b00) acks++;
            tick();
        end
        chk("t4_word", {bad, seen0, seen7}, 3'b011);
        chk("t4_acks", acks, 1);

        // 5: reset mid-SHOW aborts without ack
        bus.data0 = 32'h0BAD_F00D; bus.req = 2'b01;
        tick();
        bus.req = 2'b00;
        repeat (10) tick();
        rst = 1'b1;
        #1;
        chk("t5_gnt",  bus.gnt, 2'b00);
        chk("t5_busy", bus.busy, 1'b0);
        chk("t5_dark", {bus.an, bus.a_to_g, bus.dp}, {8'hFF, 7'h7F, 1'b1});
        tick();
        rst = 1'b0;
        acks = 0;
        repeat (50) begin
            tick();
            if (bus.ack !== 2'b00 || bus.gnt !== 2'b00) acks++;
        end
        chk("t5_noack", acks, 0);
        bus.data1 = 32'h0000_0042; bus.req = 2'b10;
        tick();
        chk("t5_gnt1", bus.gnt, 2'b10);
        bus.req = 2'b00;
        drain("t5_drain");

        // 6: leading-zero blanking (all digits active when disabled)
        bus.data0 = 32'h0000_00A5; bus.req = 2'b01;
        tick();
        bus.req = 2'b00;
        act = '0; k = 0;
        while (bus.gnt !== 2'b00 && k < 100) begin
            if (k > 0) act = act | ~bus.an;
            k++; tick();
        end
`ifdef SSD_LEADING_ZERO_BLANK_EN
        chk("t6_lz_a5", act, 8'h03);
`else
        chk("t6_all_a5", act, 8'hFF);
`endif
        drain("t6_drain");
        bus.data0 = 32'h0000_0000; bus.req = 2'b01;
        tick();
        bus.req = 2'b00;
        act = '0; k = 0;
        while (bus.gnt !== 2'b00 && k < 100) begin
            if (k > 0) act = act | ~bus.an;
            k++; tick();
        end
`ifdef SSD_LEADING_ZERO_BLANK_EN
        chk("t6_lz_zero", act, 8'h01);
`else
        chk("t6_all_zero", act, 8'hFF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
